// File: rtl/uart_byte_rx.sv
// Oversampling 8N1 UART byte receiver, LSB first.
// Synchronises rxd, votes 3 samples around mid-bit, rejects false starts,
// checks the stop bit and emits one data_ready pulse per good byte.
module uart_byte_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       data_ready,
  output logic [7:0] data,
  output logic       framing_error,
  output logic       busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  // Sample index k is the number of ticks elapsed in the bit, so it is taken
  // on the tick that advances scnt to k (scnt == k-1 during that tick).
  localparam logic [SW-1:0] S_A      = SW'(M - 2);  // sample M-1
  localparam logic [SW-1:0] S_B      = SW'(M - 1);  // sample M
  localparam logic [SW-1:0] S_VOTE   = SW'(M);      // sample M+1, vote tick

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_byte_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 8) begin : g_ovs_check
      $error("uart_byte_rx: OVERSAMPLE must be at least 8");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state, state_next;
  logic            rx_meta, rxs;
  logic [DW-1:0]   dcnt;
  logic [SW-1:0]   scnt;
  logic [2:0]      bit_idx;
  logic            samp_a, samp_b;
  logic [7:0]      shreg;
  logic            tick, vote_tick, wrap_tick, vote;
  logic            dr_set, fe_set;

  assign tick      = (state != IDLE) && (dcnt == DIV_LAST);
  assign vote_tick = tick && (scnt == S_VOTE);
  assign wrap_tick = tick && (scnt == S_LAST);
  // The third sample is the live rxs on the vote tick itself.
  assign vote      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
  assign busy      = (state != IDLE);

  // Two-flop synchroniser; resets to the idle line level so reset does not
  // look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here make rxs see the previous rx_meta,
      // giving two real flops; blocking would collapse them into one.
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Tick divider, sample counter and bit index; all held at zero in IDLE so a
  // detected start begins a clean bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt    <= '0;
      scnt    <= '0;
      bit_idx <= '0;
    end else if (state == IDLE) begin
      dcnt    <= '0;
      scnt    <= '0;
      bit_idx <= '0;
    end else begin
      dcnt <= tick ? '0 : dcnt + 1'b1;
      if (tick) begin
        scnt <= (scnt == S_LAST) ? '0 : scnt + 1'b1;
      end
      if (state == DATA && wrap_tick) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Capture the first two vote samples and shift voted data bits in LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
      shreg  <= '0;
    end else begin
      if (tick && scnt == S_A) samp_a <= rxs;
      if (tick && scnt == S_B) samp_b <= rxs;
      if (state == DATA && vote_tick) shreg <= {vote, shreg[7:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and output pulse requests.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    dr_set     = 1'b0;
    fe_set     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) state_next = START;
      end
      START: begin
        if (vote_tick && vote) state_next = IDLE;   // false start
        else if (wrap_tick)    state_next = DATA;
      end
      DATA: begin
        if (wrap_tick && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (vote_tick) begin
          if (vote) begin
            dr_set     = 1'b1;
            state_next = IDLE;
          end else begin
            fe_set     = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs; data only moves in the cycle data_ready is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      data          <= 8'h00;
    end else begin
      data_ready    <= dr_set;
      framing_error <= fe_set;
      if (dr_set) data <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 32 clks per bit (DIV = 2).
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int OVS      = 16;
  localparam int BIT_CLKS = CLK_FREQ / BAUD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic       data_ready;
  logic [7:0] data;
  logic       framing_error;
  logic       busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  // Reference model state: bytes that must appear, framing errors expected.
  logic [7:0]  exp_q[$];
  int          exp_fe  = 0;
  // What the DUT actually produced.
  logic [7:0]  got_q[$];
  int unsigned got_cyc[$];
  int          fe_seen = 0;

  logic       prev_dr   = 1'b0;
  logic       prev_fe   = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_byte_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .data_ready   (data_ready),
    .data         (data),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: records pulses and checks pulse shape and data stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dr   = 1'b0;
      prev_fe   = 1'b0;
      prev_data = 8'h00;
    end else begin
      if (data_ready) begin
        got_q.push_back(data);
        got_cyc.push_back(cyc);
      end
      if (framing_error) fe_seen++;
      if (data_ready || framing_error) begin
        check("pulse_exclusive", 32'(data_ready & framing_error), 0);
        check("pulse_width", 32'({prev_dr & data_ready, prev_fe & framing_error}), 0);
      end
      if (data !== prev_data) check("data_moves_only_with_ready", 32'(data_ready), 1);
      prev_dr   = data_ready;
      prev_fe   = framing_error;
      prev_data = data;
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One bit cell of per clks; optional 2-clk inversion around the middle sample.
  task automatic drive_bit(input logic v, input int per, input bit glitch);
    for (int k = 0; k < per; k++) begin
      rxd = (glitch && (k == 15 || k == 16)) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // start + 8 data bits LSB first + stop; glitch_bit < 0 means no glitch.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per,
                            input int glitch_bit, output int unsigned start_cyc);
    logic [9:0] frame;
    frame     = {stop, b, 1'b0};
    start_cyc = cyc;
    for (int j = 0; j < 10; j++) begin
      drive_bit(frame[j], per, (glitch_bit >= 0) && (j == glitch_bit + 1));
    end
  endtask

  task automatic expect_bytes(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int unsigned t_start;
    int          lat;
    int          per;
    int          gap;
    logic [7:0]  b;
    logic        good;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'h00);
    check("reset_data_ready", 32'(data_ready), 0);
    check("reset_framing_error", 32'(framing_error), 0);
    check("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(10);
    check("after_reset_busy", 32'(busy), 0);

    // Single byte with latency measured from start detection (2 clks after edge).
    send_frame(8'hA5, 1'b1, BIT_CLKS, -1, t_start);
    idle(20);
    exp_q.push_back(8'hA5);
    lat = (got_cyc.size() > 0) ? int'(got_cyc[0] - t_start) - 2 : 0;
    check("single_latency_in_window", 32'(lat >= 304 && lat <= 308), 1);
    check("single_data", 32'(data), 32'hA5);
    check("single_busy_after", 32'(busy), 0);
    check("single_no_fe", 32'(fe_seen), 32'(exp_fe));
    expect_bytes("single");

    // Streaming 216 bytes with no idle gap.
    for (int i = 0; i < 216; i++) begin
      send_frame(8'(i), 1'b1, BIT_CLKS, -1, t_start);
      exp_q.push_back(8'(i));
    end
    idle(20);
    check("stream_no_fe", 32'(fe_seen), 32'(exp_fe));
    expect_bytes("stream");

    // False start: 6-clk low pulse.
    rxd = 1'b0;
    repeat (6) @(negedge clk);
    rxd = 1'b1;
    check("false_start_busy_during", 32'(busy), 1);
    idle(40);
    check("false_start_busy_after", 32'(busy), 0);
    check("false_start_no_fe", 32'(fe_seen), 32'(exp_fe));
    check("false_start_data_kept", 32'(data), 32'hD7);
    expect_bytes("false_start");

    // Framing error followed by a long break, then a good byte.
    send_frame(8'h3C, 1'b0, BIT_CLKS, -1, t_start);
    rxd = 1'b0;
    repeat (500) @(negedge clk);
    idle(40);
    exp_fe++;
    check("break_single_fe", 32'(fe_seen), 32'(exp_fe));
    check("break_data_kept", 32'(data), 32'hD7);
    check("break_busy_after", 32'(busy), 0);
    expect_bytes("break_none");
    send_frame(8'h81, 1'b1, BIT_CLKS, -1, t_start);
    idle(20);
    exp_q.push_back(8'h81);
    check("after_break_data", 32'(data), 32'h81);
    expect_bytes("after_break");

    // Single-sample glitch on bit 3 must be outvoted.
    send_frame(8'h55, 1'b1, BIT_CLKS, 3, t_start);
    idle(20);
    exp_q.push_back(8'h55);
    check("glitch_data", 32'(data), 32'h55);
    expect_bytes("glitch");

    // Reset during bit 4 of 0xFF.
    drive_bit(1'b0, BIT_CLKS, 1'b0);
    for (int j = 0; j < 4; j++) drive_bit(1'b1, BIT_CLKS, 1'b0);
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_data_ready", 32'(data_ready), 0);
    check("midreset_framing_error", 32'(framing_error), 0);
    check("midreset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(40);
    check("midreset_no_pulse", 32'(got_q.size()), 0);
    send_frame(8'h12, 1'b1, BIT_CLKS, -1, t_start);
    idle(20);
    exp_q.push_back(8'h12);
    check("midreset_next_data", 32'(data), 32'h12);
    check("midreset_fe_total", 32'(fe_seen), 32'(exp_fe));
    expect_bytes("midreset");

    // Random bytes, random +/-3 % bit period, occasional bad stop bit.
    for (int i = 0; i < 24; i++) begin
      per  = int'($urandom_range(31, 33));
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(b, good, per, -1, t_start);
      if (good) begin
        exp_q.push_back(b);
        gap = int'($urandom_range(0, 20));
      end else begin
        exp_fe++;
        gap = per + int'($urandom_range(0, 20));
      end
      idle(gap);
    end
    idle(40);
    check("random_fe_total", 32'(fe_seen), 32'(exp_fe));
    check("random_busy_after", 32'(busy), 0);
    expect_bytes("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
